// File: rtl/fifo_chk_pkg.sv
// Shared state encodings and widths for the FIFO drain checker.
package fifo_chk_pkg;

  localparam int STATE_W = 2;
  localparam int TMR_N   = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_FULL = 2'd1,
    ST_DRAIN     = 2'd2,
    ST_FLUSH     = 2'd3
  } state_e;

endpackage

// File: rtl/mvtr.sv
// Bitwise M-of-N majority voter: M copies of an N-bit word, vote and per-bit disagreement.
module mvtr #(
  parameter int M = 3,
  parameter int N = 2
) (
  input  logic [M*N-1:0] data_i,
  output logic [N-1:0]   vote_o,
  output logic [N-1:0]   disagree_o
);

  for (genvar gi = 0; gi < N; gi++) begin : g_bit
    int ones;
    always_comb begin
      ones = 0;
      for (int m = 0; m < M; m++) begin
        ones = ones + int'(data_i[m*N+gi]);
      end
      vote_o[gi]     = (2 * ones > M);
      disagree_o[gi] = (ones != 0) && (ones != M);
    end
  end

endmodule

// File: rtl/fifo_drain_checker.sv
// Drains a FIFO once almost-full and checks the words form an incrementing sequence.
// Define FIFO_CHK_TMR_EN to triplicate the state register behind a majority voter.
module fifo_drain_checker
  import fifo_chk_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ERR_W  = 16,
  parameter int RD_LAT = 1
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              fifo_almst_full_i,
  input  logic              fifo_empty_i,
  input  logic [DATA_W-1:0] fifo_data_i,
  output logic              fifo_rd_o,
  output logic [31:0]       word_cnt_o,
  output logic [ERR_W-1:0]  err_cnt_o,
  output logic              err_o,
  output logic              busy_o,
  output logic              warn_o
);

  localparam logic [1:0] FLUSH_LOAD = 2'(RD_LAT - 1);

  state_e state_v, state_d;
  logic [1:0] flush_cnt_q, flush_cnt_d;
  logic [RD_LAT-1:0] vld_q, vld_d;
  logic seeded_q, seeded_d;
  logic [DATA_W-1:0] exp_q, exp_d;
  logic [31:0] word_cnt_q, word_cnt_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic err_q, err_d;
  logic chk;

`ifdef FIFO_CHK_TMR_EN
  logic [TMR_N*STATE_W-1:0] copies;
  logic [STATE_W-1:0] vote, disagree;

  for (genvar gi = 0; gi < TMR_N; gi++) begin : g_copy
    logic [STATE_W-1:0] copy_q;
    always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) copy_q <= ST_IDLE;
      else         copy_q <= state_d;
    end
    assign copies[gi*STATE_W +: STATE_W] = copy_q;
  end

  mvtr #(.M(TMR_N), .N(STATE_W)) u_mvtr (
    .data_i     (copies),
    .vote_o     (vote),
    .disagree_o (disagree)
  );

  assign state_v = state_e'(vote);
  assign warn_o  = |disagree;
`else
  state_e state_q;
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end
  assign state_v = state_q;
  assign warn_o  = 1'b0;
`endif

  assign fifo_rd_o = (state_v == ST_DRAIN) && !fifo_empty_i;
  assign busy_o    = (state_v == ST_DRAIN) || (state_v == ST_FLUSH);

  always_comb begin
    state_d     = state_v;
    flush_cnt_d = flush_cnt_q;
    case (state_v)
      ST_IDLE:      state_d = ST_WAIT_FULL;
      ST_WAIT_FULL: if (fifo_almst_full_i) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (fifo_empty_i) begin
          state_d     = ST_FLUSH;
          flush_cnt_d = FLUSH_LOAD;
        end
      end
      ST_FLUSH: begin
        // Stay long enough for every read issued in DRAIN to return its data.
        if (flush_cnt_q == 2'd0) state_d = ST_WAIT_FULL;
        else                     flush_cnt_d = flush_cnt_q - 2'd1;
      end
      default:      state_d = ST_IDLE;
    endcase
  end

  assign chk = vld_q[RD_LAT-1];

  always_comb begin
    vld_d      = vld_q << 1;
    vld_d[0]   = fifo_rd_o;
    seeded_d   = seeded_q;
    exp_d      = exp_q;
    word_cnt_d = word_cnt_q;
    err_cnt_d  = err_cnt_q;
    err_d      = 1'b0;
    if (chk) begin
      word_cnt_d = word_cnt_q + 32'd1;
      if (!seeded_q) begin
        seeded_d = 1'b1;
        exp_d    = fifo_data_i + DATA_W'(1);
      end else begin
        exp_d = exp_q + DATA_W'(1);
        if (fifo_data_i != exp_q) begin
          err_d = 1'b1;
          if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      flush_cnt_q <= 2'd0;
      vld_q       <= '0;
      seeded_q    <= 1'b0;
      exp_q       <= '0;
      word_cnt_q  <= '0;
      err_cnt_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      flush_cnt_q <= flush_cnt_d;
      vld_q       <= vld_d;
      seeded_q    <= seeded_d;
      exp_q       <= exp_d;
      word_cnt_q  <= word_cnt_d;
      err_cnt_q   <= err_cnt_d;
      err_q       <= err_d;
    end
  end

  assign word_cnt_o = word_cnt_q;
  assign err_cnt_o  = err_cnt_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_fifo_drain_checker.sv
// Scoreboard bench: dut1 (RD_LAT=1, ERR_W=2) is monitored per checked word, dut3 (RD_LAT=3) covers reset mid-drain.
module tb_fifo_drain_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // ---------------- dut1 ----------------
  logic        rstn1, almst1, rd1, err1, busy1, warn1;
  logic        empty1 = 1'b1;
  logic [31:0] data1 = 32'd0;
  logic [31:0] wc1;
  logic [1:0]  ec1;
  logic [31:0] q1[$];

  fifo_drain_checker #(.DATA_W(32), .ERR_W(2), .RD_LAT(1)) dut1 (
    .clk_i(clk), .rstn_i(rstn1), .fifo_almst_full_i(almst1), .fifo_empty_i(empty1),
    .fifo_data_i(data1), .fifo_rd_o(rd1), .word_cnt_o(wc1), .err_cnt_o(ec1),
    .err_o(err1), .busy_o(busy1), .warn_o(warn1)
  );

  // ---------------- dut3 ----------------
  logic        rstn3, almst3, rd3, err3, busy3, warn3;
  logic        empty3 = 1'b1;
  logic [31:0] p3[3];
  logic [31:0] data3;
  logic [31:0] wc3;
  logic [15:0] ec3;
  logic [31:0] q3[$];

  fifo_drain_checker #(.DATA_W(32), .ERR_W(16), .RD_LAT(3)) dut3 (
    .clk_i(clk), .rstn_i(rstn3), .fifo_almst_full_i(almst3), .fifo_empty_i(empty3),
    .fifo_data_i(data3), .fifo_rd_o(rd3), .word_cnt_o(wc3), .err_cnt_o(ec3),
    .err_o(err3), .busy_o(busy3), .warn_o(warn3)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // FIFO models: data appears RD_LAT cycles after a read.
  always @(posedge clk) begin
    if (rd1) begin
      if (q1.size() != 0) data1 <= q1.pop_front();
      else chk("fifo1_underrun", 32'd1, 32'd0);
    end
    empty1 <= (q1.size() == 0);
  end

  always @(posedge clk) begin
    p3[0] <= 32'hDEAD_BEEF;
    if (rd3) begin
      if (q3.size() != 0) p3[0] <= q3.pop_front();
      else chk("fifo3_underrun", 32'd1, 32'd0);
    end
    p3[1]  <= p3[0];
    p3[2]  <= p3[1];
    empty3 <= (q3.size() == 0);
  end
  assign data3 = p3[2];

  // ---------------- scoreboard / monitor ----------------
  typedef struct packed {
    logic        err;
    logic [31:0] ecnt;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] exp_wc = 32'd0;
  int rdc1 = 0, idle1 = 0, errp1 = 0, errp3 = 0, idle3 = 0;

  always @(negedge clk) begin
    exp_t e;
    if (!rstn1) begin
      exp_wc = 32'd0;
    end else begin
      if (rd1) rdc1++;
      if (busy1 && !rd1) idle1++;
      if (err1) errp1++;
      if (wc1 != exp_wc) begin
        exp_wc = exp_wc + 32'd1;
        if (sb.size() == 0) begin
          chk("unexpected_word", wc1, exp_wc - 32'd1);
        end else begin
          e = sb.pop_front();
          $display("word %0d checked: err_o=%0b err_cnt=%0d (exp err_o=%0b err_cnt=%0d)",
                   wc1, err1, ec1, e.err, e.ecnt);
          chk("word_cnt", wc1, exp_wc);
          chk("err_o", {31'd0, err1}, {31'd0, e.err});
          chk("err_cnt", {30'd0, ec1}, e.ecnt);
        end
      end else if (err1) begin
        chk("err_o_without_word", 32'd1, 32'd0);
      end
    end
    if (err3) errp3++;
    if (busy3 && !rd3) idle3++;
  end

  task automatic push1(input logic [31:0] w, input logic e, input logic [31:0] ec);
    q1.push_back(w);
    sb.push_back('{err: e, ecnt: ec});
  endtask

  task automatic reset1();
    @(negedge clk);
    rstn1 = 1'b0;
    @(negedge clk);
    rstn1 = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_idle(input int which);
    bit seen = 0;
    bit done = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if ((which == 1) ? busy1 : busy3) seen = 1;
      else if (seen) begin
        done = 1;
        break;
      end
    end
    if (!done) chk("drain_timeout", 32'd0, 32'd1);
  endtask

  task automatic run1(input int nwords);
    int r0 = rdc1;
    int i0 = idle1;
    @(negedge clk);
    almst1 = 1'b1;
    @(negedge clk);
    almst1 = 1'b0;
    wait_idle(1);
    repeat (3) @(negedge clk);
    chk("rd_count", 32'(rdc1 - r0), 32'(nwords));
    chk("empty_to_wait_full", 32'(idle1 - i0), 32'd2);
    chk("sb_drained", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int e0, i0;
    rstn1 = 1'b0; rstn3 = 1'b0; almst1 = 1'b0; almst3 = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_rd", {31'd0, rd1}, 32'd0);
    chk("rst_wc", wc1, 32'd0);
    chk("rst_ec", {30'd0, ec1}, 32'd0);
    chk("rst_err", {31'd0, err1}, 32'd0);
    chk("rst_busy", {31'd0, busy1}, 32'd0);
    chk("rst_warn", {31'd0, warn1}, 32'd0);
    rstn1 = 1'b1; rstn3 = 1'b1;
    repeat (2) @(negedge clk);

    $display("test: 8 words 0..7");
    for (int i = 0; i < 8; i++) push1(32'(i), 1'b0, 32'd0);
    run1(8);
    chk("t1_wc", wc1, 32'd8);
    chk("t1_ec", {30'd0, ec1}, 32'd0);

    $display("test: 10,11,99,13");
    reset1();
    e0 = errp1;
    push1(32'd10, 1'b0, 32'd0);
    push1(32'd11, 1'b0, 32'd0);
    push1(32'd99, 1'b1, 32'd1);
    push1(32'd13, 1'b0, 32'd1);
    run1(4);
    chk("t2_ec", {30'd0, ec1}, 32'd1);
    chk("t2_pulses", 32'(errp1 - e0), 32'd1);

    $display("test: saturation with 5 bad words");
    reset1();
    e0 = errp1;
    push1(32'd0, 1'b0, 32'd0);
    push1(32'd50, 1'b1, 32'd1);
    push1(32'd60, 1'b1, 32'd2);
    push1(32'd70, 1'b1, 32'd3);
    push1(32'd80, 1'b1, 32'd3);
    push1(32'd90, 1'b1, 32'd3);
    run1(6);
    chk("t3_ec", {30'd0, ec1}, 32'd3);
    chk("t3_pulses", 32'(errp1 - e0), 32'd5);

    $display("test: wraparound");
    reset1();
    push1(32'hFFFF_FFFE, 1'b0, 32'd0);
    push1(32'hFFFF_FFFF, 1'b0, 32'd0);
    push1(32'h0000_0000, 1'b0, 32'd0);
    push1(32'h0000_0001, 1'b0, 32'd0);
    run1(4);
    chk("t4_ec", {30'd0, ec1}, 32'd0);
    chk("t4_wc", wc1, 32'd4);

`ifdef FIFO_CHK_TMR_EN
    $display("test: state copy upset in WAIT_FULL");
    @(negedge clk);
    force dut1.g_copy[1].copy_q = 2'd3;
    #1;
    chk("tmr_warn", {31'd0, warn1}, 32'd1);
    chk("tmr_rd", {31'd0, rd1}, 32'd0);
    chk("tmr_busy", {31'd0, busy1}, 32'd0);
    release dut1.g_copy[1].copy_q;
    @(negedge clk);
    chk("tmr_warn_clear", {31'd0, warn1}, 32'd0);
    chk("tmr_rd_after", {31'd0, rd1}, 32'd0);
`endif

    $display("test: reset mid-drain, RD_LAT=3");
    for (int i = 0; i < 10; i++) q3.push_back(32'd100 + 32'(i));
    @(negedge clk);
    almst3 = 1'b1;
    @(negedge clk);
    almst3 = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (wc3 >= 32'd2) break;
      @(negedge clk);
    end
    chk("t5_wc_before", {31'd0, (wc3 >= 32'd2)}, 32'd1);
    chk("t5_rd_before", {31'd0, rd3}, 32'd1);
    rstn3 = 1'b0;
    #1;
    chk("t5_rst_rd", {31'd0, rd3}, 32'd0);
    chk("t5_rst_wc", wc3, 32'd0);
    chk("t5_rst_ec", {16'd0, ec3}, 32'd0);
    chk("t5_rst_err", {31'd0, err3}, 32'd0);
    chk("t5_rst_busy", {31'd0, busy3}, 32'd0);
    q3.delete();
    for (int i = 0; i < 4; i++) q3.push_back(32'd500 + 32'(i));
    @(negedge clk);
    rstn3 = 1'b1;
    repeat (2) @(negedge clk);
    e0 = errp3;
    i0 = idle3;
    almst3 = 1'b1;
    @(negedge clk);
    almst3 = 1'b0;
    wait_idle(3);
    repeat (5) @(negedge clk);
    $display("dut3 after re-seed drain: word_cnt=%0d err_cnt=%0d", wc3, ec3);
    chk("t5_wc", wc3, 32'd4);
    chk("t5_ec", {16'd0, ec3}, 32'd0);
    chk("t5_pulses", 32'(errp3 - e0), 32'd0);
    chk("t5_flush_len", 32'(idle3 - i0), 32'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fifo_drain_checker.md
FIFO_DRAIN_CHECKER -- requirements
Module: fifo_drain_checker

Interface
REQ-001 SHALL have parameter DATA_W, default 32: FIFO data width in bits.
REQ-002 SHALL have parameter ERR_W, default 16: error counter width.
REQ-003 SHALL have parameter RD_LAT, default 1: FIFO read-to-data latency in cycles, range 1-4.
REQ-004 SHALL have port clk_i  in  1: single clock; all logic rising-edge.
REQ-005 SHALL have port rstn_i  in  1: reset, asynchronous, active-low.
REQ-006 SHALL have port fifo_almst_full_i  in  1: drained FIFO almost-full flag.
REQ-007 SHALL have port fifo_empty_i  in  1: drained FIFO empty flag.
REQ-008 SHALL have port fifo_data_i  in  DATA_W: FIFO read data, valid RD_LAT cycles after fifo_rd_o.
REQ-009 SHALL have port fifo_rd_o  out  1: FIFO read enable.
REQ-010 SHALL have port word_cnt_o  out  32: words checked, wraps at 2^32.
REQ-011 SHALL have port err_cnt_o  out  ERR_W: mismatches, saturating.
REQ-012 SHALL have port err_o  out  1: one-cycle pulse per mismatch.
REQ-013 SHALL have port busy_o  out  1: high in DRAIN or FLUSH.
REQ-014 SHALL have port warn_o  out  1: state voter disagreement flag.

Function
REQ-015 SHALL implement states IDLE=0, WAIT_FULL=1, DRAIN=2, FLUSH=3.
REQ-016 SHALL move IDLE->WAIT_FULL unconditionally on the first cycle after reset.
REQ-017 SHALL move WAIT_FULL->DRAIN when fifo_almst_full_i=1; otherwise it stays in WAIT_FULL.
REQ-018 SHALL drive fifo_rd_o = (state==DRAIN) & !fifo_empty_i, combinationally from the voted state; it SHALL never read an empty FIFO.
REQ-019 SHALL move DRAIN->FLUSH in the first cycle with fifo_empty_i=1.
REQ-020 SHALL hold FLUSH for exactly RD_LAT cycles, counted by a down-counter loaded on entry, then go to WAIT_FULL.
REQ-021 SHALL track issued reads in an RD_LAT-deep valid shift register; a word is checked only when the shift-register output is 1.
REQ-022 SHALL treat the first checked word after reset as the seed: expected <= data+1, no comparison, word_cnt_o incremented.
REQ-023 SHALL compare each later checked word against expected; expected <= expected+1 on every checked word, regardless of match, wrapping mod 2^DATA_W.
REQ-024 SHALL, on a mismatch, register err_o=1 for one cycle, one cycle after the data is valid, and increment err_cnt_o, holding at all-ones.
REQ-025 SHALL, on all-ones to zero data wraparound with expected all-ones+1=0, not flag an error.
REQ-026 SHALL check data in flight when fifo_almst_full_i re-asserts during FLUSH, and reads SHALL resume only after WAIT_FULL.
REQ-027 SHALL treat any state encoding outside 0-3 as IDLE on the next cycle.

Reset
REQ-028 SHALL, with rstn_i=0, immediately clear state to IDLE, the valid pipeline, the FLUSH counter, the seed flag, expected, word_cnt_o, err_cnt_o and err_o; fifo_rd_o, busy_o and warn_o SHALL be 0.
REQ-029 SHALL discard data for reads pending when reset asserts mid-DRAIN; after release, the next checked word re-seeds.

Configuration
REQ-030 SHALL, with macro FIFO_CHK_TMR_EN defined, hold the state register as three copies, each written identically and voted bitwise 2-of-3; warn_o = OR of the per-bit disagreements.
REQ-031 SHALL, without FIFO_CHK_TMR_EN, use a single state register and tie warn_o to 0; all other behaviour SHALL be identical.

Structure
REQ-032 SHALL take the state encodings, state width (2) and TMR copy count (3) from shared package fifo_chk_pkg.
REQ-033 SHALL instantiate the existing majority voter sub-module mvtr (M=3, N=2) only under FIFO_CHK_TMR_EN.
REQ-034 SHALL fit in 120-400 lines of RTL.

Verification
REQ-035 SHALL cover: reset, then almst_full=1, then 8 words 0..7 with RD_LAT=1 -> 8 reads, word_cnt_o=8, err_cnt_o=0, return to WAIT_FULL after empty plus 1 cycle.
REQ-036 SHALL cover: stream 10,11,99,13 -> exactly one err_o pulse, on the cycle after 99 is valid, and err_cnt_o=1.
REQ-037 SHALL cover: ERR_W=2 with 5 corrupted words -> err_cnt_o saturates at 3 and err_o pulses 5 times.
REQ-038 SHALL cover: data FFFFFFFE,FFFFFFFF,0,1 -> err_cnt_o=0.
REQ-039 SHALL cover: rstn_i low for 1 cycle mid-DRAIN with RD_LAT=3 -> fifo_rd_o=0 in the same cycle, all counters 0, and the next word re-seeds with no error.
REQ-040 SHALL cover, with FIFO_CHK_TMR_EN: force one state copy to 3 during WAIT_FULL -> warn_o=1, fifo_rd_o stays 0, and the copy is rewritten on the next clock.
